// File: rtl/sr_pkg.sv
// ============================================================================
// Module : sr_pkg
// Shared types and encodings for the schoolRISCV multi-cycle control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sr_pkg;

    typedef enum logic [0:0] {
        ST_EXEC = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [1:0] MDOP_MUL  = 2'b00;
    localparam logic [1:0] MDOP_DIVU = 2'b01;
    localparam logic [1:0] MDOP_REMU = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_IMM = 2'b01;
    localparam logic [1:0] WD_MD  = 2'b10;

    // Mirrors the ALU/opcode encodings of the core include so this unit is standalone
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SRL  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_B   = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

endpackage

`default_nettype wire

// File: rtl/sr_decode.sv
// ============================================================================
// Module : sr_decode
// Combinational decode of {funct7, funct3, opcode} into control bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sr_decode
    import sr_pkg::*;
#(
    parameter bit DIV_EN = 1'b1
) (
    input  logic [6:0] cmdOp,
    input  logic [2:0] cmdF3,
    input  logic [6:0] cmdF7,
    output logic       regWrite,
    output logic       aluSrc,
    output logic [1:0] wdSrc,
    output logic [2:0] aluControl,
    output logic       branch,
    output logic       condZero,
    output logic       isMd,
    output logic [1:0] mdOp,
    output logic       illegal
);

    always_comb begin
        regWrite   = 1'b0;
        aluSrc     = 1'b0;
        wdSrc      = WD_ALU;
        aluControl = ALU_ADD;
        branch     = 1'b0;
        condZero   = 1'b0;
        isMd       = 1'b0;
        mdOp       = MDOP_MUL;
        illegal    = 1'b0;

        casez ({cmdF7, cmdF3, cmdOp})
            {F7_BASE, 3'b000, OP_R}: begin regWrite = 1'b1; aluControl = ALU_ADD;  end
            {F7_SUB,  3'b000, OP_R}: begin regWrite = 1'b1; aluControl = ALU_SUB;  end
            {F7_BASE, 3'b110, OP_R}: begin regWrite = 1'b1; aluControl = ALU_OR;   end
            {F7_BASE, 3'b101, OP_R}: begin regWrite = 1'b1; aluControl = ALU_SRL;  end
            {F7_BASE, 3'b011, OP_R}: begin regWrite = 1'b1; aluControl = ALU_SLTU; end
            {F7_MD,   3'b000, OP_R}: begin isMd = 1'b1; mdOp = MDOP_MUL; end
            {F7_MD,   3'b101, OP_R}: begin
                mdOp = MDOP_DIVU;
                if (DIV_EN) isMd    = 1'b1;
                else        illegal = 1'b1;
            end
            {F7_MD,   3'b111, OP_R}: begin
                mdOp = MDOP_REMU;
                if (DIV_EN) isMd    = 1'b1;
                else        illegal = 1'b1;
            end
            {7'b???????, 3'b000, OP_I}:   begin regWrite = 1'b1; aluSrc = 1'b1; end
            {7'b???????, 3'b???, OP_LUI}: begin regWrite = 1'b1; wdSrc = WD_IMM; end
            {7'b???????, 3'b000, OP_B}: begin
                branch     = 1'b1;
                condZero   = 1'b1;
                aluControl = ALU_SUB;
            end
            {7'b???????, 3'b001, OP_B}: begin
                branch     = 1'b1;
                aluControl = ALU_SUB;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/sr_control_mc.sv
// ============================================================================
// Module : sr_control_mc
// Control unit that stalls the core around long MUL/DIVU/REMU operations.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sr_control_mc
    import sr_pkg::*;
#(
    parameter bit DIV_EN     = 1'b1,
    parameter int MD_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] cmdOp,
    input  logic [2:0] cmdF3,
    input  logic [6:0] cmdF7,
    input  logic       aluZero,
    input  logic       mdVld,
    output logic       pcEn,
    output logic       pcSrc,
    output logic       regWrite,
    output logic       aluSrc,
    output logic [1:0] wdSrc,
    output logic [2:0] aluControl,
    output logic       mdStart,
    output logic [1:0] mdOp,
    output logic       illegal,
    output logic       mdErr
);

    localparam int               CNT_W    = $clog2(MD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    logic       dec_reg_write;
    logic       dec_alu_src;
    logic [1:0] dec_wd_src;
    logic [2:0] dec_alu_control;
    logic       dec_branch;
    logic       dec_cond_zero;
    logic       dec_is_md;
    logic [1:0] dec_md_op;
    logic       dec_illegal;

    sr_decode #(
        .DIV_EN (DIV_EN)
    ) u_decode (
        .cmdOp      (cmdOp),
        .cmdF3      (cmdF3),
        .cmdF7      (cmdF7),
        .regWrite   (dec_reg_write),
        .aluSrc     (dec_alu_src),
        .wdSrc      (dec_wd_src),
        .aluControl (dec_alu_control),
        .branch     (dec_branch),
        .condZero   (dec_cond_zero),
        .isMd       (dec_is_md),
        .mdOp       (dec_md_op),
        .illegal    (dec_illegal)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EXEC;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        timeout_hit = 1'b0;

        pcEn        = 1'b1;
        pcSrc       = 1'b0;
        regWrite    = 1'b0;
        aluSrc      = dec_alu_src;
        wdSrc       = dec_wd_src;
        aluControl  = dec_alu_control;
        mdStart     = 1'b0;
        mdOp        = dec_md_op;
        illegal     = dec_illegal;

        case (state_q)
            ST_EXEC: begin
                if (dec_illegal) begin
                    pcEn = 1'b1;
                end else if (dec_is_md) begin
                    // Start is held off while reset is asserted so the unit is not kicked mid-reset
                    mdStart = rst_n;
                    pcEn    = 1'b0;
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                end else begin
                    regWrite = dec_reg_write;
                    pcSrc    = dec_branch & (aluZero == dec_cond_zero);
                end
            end
            ST_BUSY: begin
                pcEn = 1'b0;
                // A result arriving on the final count beats the timeout
                if (mdVld) begin
                    regWrite = 1'b1;
                    wdSrc    = WD_MD;
                    pcEn     = 1'b1;
                    state_d  = ST_EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    err_d       = 1'b1;
                    pcEn        = 1'b1;
                    state_d     = ST_EXEC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_EXEC;
        endcase
    end

    assign mdErr = err_q | timeout_hit;

endmodule

`default_nettype wire

// File: tb/tb_sr_control_mc.sv
// ============================================================================
// Module : tb_sr_control_mc
// Directed vector bench for sr_control_mc (DIV_EN=1 and DIV_EN=0 instances).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sr_control_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] cmdOp;
    logic [2:0] cmdF3;
    logic [6:0] cmdF7;
    logic       aluZero;
    logic       mdVld;

    logic       pcEn, pcSrc, regWrite, aluSrc, mdStart, illegal, mdErr;
    logic [1:0] wdSrc, mdOp;
    logic [2:0] aluControl;

    logic       nd_pcEn, nd_pcSrc, nd_regWrite, nd_aluSrc, nd_mdStart, nd_illegal, nd_mdErr;
    logic [1:0] nd_wdSrc, nd_mdOp;
    logic [2:0] nd_aluControl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sr_control_mc #(.DIV_EN(1'b1), .MD_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
        .aluZero(aluZero), .mdVld(mdVld), .pcEn(pcEn), .pcSrc(pcSrc),
        .regWrite(regWrite), .aluSrc(aluSrc), .wdSrc(wdSrc), .aluControl(aluControl),
        .mdStart(mdStart), .mdOp(mdOp), .illegal(illegal), .mdErr(mdErr)
    );

    sr_control_mc #(.DIV_EN(1'b0), .MD_TIMEOUT(16)) dut_nd (
        .clk(clk), .rst_n(rst_n), .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7),
        .aluZero(aluZero), .mdVld(mdVld), .pcEn(nd_pcEn), .pcSrc(nd_pcSrc),
        .regWrite(nd_regWrite), .aluSrc(nd_aluSrc), .wdSrc(nd_wdSrc),
        .aluControl(nd_aluControl), .mdStart(nd_mdStart), .mdOp(nd_mdOp),
        .illegal(nd_illegal), .mdErr(nd_mdErr)
    );

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       az;
        logic       vld;
        logic       rw;
        logic       as;
        logic [1:0] wd;
        logic [2:0] alu;
        logic       ps;
        logic       pe;
        logic       ms;
        logic       il;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        cmdOp = op;
        cmdF3 = f3;
        cmdF7 = f7;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            op          f3      f7          az   vld  rw   as   wd     alu     ps   pe   ms   il
        vecs[0]  = '{7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{7'b0110011, 3'b110, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{7'b0110011, 3'b101, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{7'b0110011, 3'b011, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{7'b0110011, 3'b000, 7'b0100000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{7'b0010011, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{7'b0110111, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{7'b1100011, 3'b000, 7'b0000000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{7'b1100011, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{7'b1100011, 3'b001, 7'b0000000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 3'b100, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{7'b1100011, 3'b001, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b100, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{7'b0110011, 3'b000, 7'b0000000, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{7'b1111111, 3'b000, 7'b0000000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{7'b0110011, 3'b000, 7'b0000010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{7'b0110011, 3'b001, 7'b0000001, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state with ADD on the bus
        rst_n   = 1'b0;
        aluZero = 1'b0;
        mdVld   = 1'b0;
        set_cmd(7'b0110011, 3'b000, 7'b0000000);
        #2;
        chk("reset mdErr", 8'(mdErr), 8'h0);
        chk("reset pcEn", 8'(pcEn), 8'h1);
        chk("reset mdStart", 8'(mdStart), 8'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Short-op vector table
        for (int i = 0; i < NVEC; i++) begin
            set_cmd(vecs[i].op, vecs[i].f3, vecs[i].f7);
            aluZero = vecs[i].az;
            mdVld   = vecs[i].vld;
            #1;
            chk($sformatf("vec%0d regWrite", i), 8'(regWrite), 8'(vecs[i].rw));
            chk($sformatf("vec%0d aluSrc", i), 8'(aluSrc), 8'(vecs[i].as));
            chk($sformatf("vec%0d wdSrc", i), 8'(wdSrc), 8'(vecs[i].wd));
            chk($sformatf("vec%0d aluControl", i), 8'(aluControl), 8'(vecs[i].alu));
            chk($sformatf("vec%0d pcSrc", i), 8'(pcSrc), 8'(vecs[i].ps));
            chk($sformatf("vec%0d pcEn", i), 8'(pcEn), 8'(vecs[i].pe));
            chk($sformatf("vec%0d mdStart", i), 8'(mdStart), 8'(vecs[i].ms));
            chk($sformatf("vec%0d illegal", i), 8'(illegal), 8'(vecs[i].il));
            tick();
        end
        aluZero = 1'b0;
        mdVld   = 1'b0;

        // MUL with result in cycle 3
        set_cmd(7'b0110011, 3'b000, 7'b0000001);
        #1;
        chk("mul c0 mdStart", 8'(mdStart), 8'h1);
        chk("mul c0 pcEn", 8'(pcEn), 8'h0);
        chk("mul c0 mdOp", 8'(mdOp), 8'h0);
        for (int c = 1; c <= 2; c++) begin
            tick();
            chk($sformatf("mul c%0d pcEn", c), 8'(pcEn), 8'h0);
            chk($sformatf("mul c%0d regWrite", c), 8'(regWrite), 8'h0);
            chk($sformatf("mul c%0d mdStart", c), 8'(mdStart), 8'h0);
        end
        tick();
        mdVld = 1'b1;
        #1;
        chk("mul c3 regWrite", 8'(regWrite), 8'h1);
        chk("mul c3 wdSrc", 8'(wdSrc), 8'h2);
        chk("mul c3 pcEn", 8'(pcEn), 8'h1);
        tick();
        mdVld = 1'b0;
        set_cmd(7'b0110011, 3'b000, 7'b0000000);
        #1;
        chk("mul c4 exec pcEn", 8'(pcEn), 8'h1);
        chk("mul c4 exec regWrite", 8'(regWrite), 8'h1);
        chk("mul c4 exec wdSrc", 8'(wdSrc), 8'h0);
        tick();

        // DIVU with result on the final count: result wins, no error
        set_cmd(7'b0110011, 3'b101, 7'b0000001);
        #1;
        chk("col c0 mdStart", 8'(mdStart), 8'h1);
        chk("col c0 mdOp", 8'(mdOp), 8'h1);
        for (int c = 1; c <= 15; c++) tick();
        chk("col c15 pcEn", 8'(pcEn), 8'h0);
        tick();
        mdVld = 1'b1;
        #1;
        chk("col c16 regWrite", 8'(regWrite), 8'h1);
        chk("col c16 wdSrc", 8'(wdSrc), 8'h2);
        chk("col c16 mdErr", 8'(mdErr), 8'h0);
        tick();
        mdVld = 1'b0;
        set_cmd(7'b0110011, 3'b000, 7'b0000000);
        #1;
        chk("col c17 mdErr", 8'(mdErr), 8'h0);
        chk("col c17 pcEn", 8'(pcEn), 8'h1);
        tick();

        // DIVU timeout
        set_cmd(7'b0110011, 3'b101, 7'b0000001);
        #1;
        chk("to c0 mdStart", 8'(mdStart), 8'h1);
        for (int c = 1; c <= 15; c++) begin
            tick();
            chk($sformatf("to c%0d pcEn", c), 8'(pcEn), 8'h0);
            chk($sformatf("to c%0d mdErr", c), 8'(mdErr), 8'h0);
        end
        tick();
        chk("to c16 mdErr", 8'(mdErr), 8'h1);
        chk("to c16 pcEn", 8'(pcEn), 8'h1);
        chk("to c16 regWrite", 8'(regWrite), 8'h0);
        set_cmd(7'b0110011, 3'b000, 7'b0000000);
        tick();
        chk("to c17 mdErr sticky", 8'(mdErr), 8'h1);
        chk("to c17 pcEn", 8'(pcEn), 8'h1);
        tick();
        chk("to c18 mdErr sticky", 8'(mdErr), 8'h1);

        // REMU interrupted by reset in cycle 2
        set_cmd(7'b0110011, 3'b111, 7'b0000001);
        #1;
        chk("remu c0 mdStart", 8'(mdStart), 8'h1);
        chk("remu c0 mdOp", 8'(mdOp), 8'h2);
        tick();
        tick();
        chk("remu c2 pcEn", 8'(pcEn), 8'h0);
        chk("remu c2 mdStart", 8'(mdStart), 8'h0);
        rst_n = 1'b0;
        #1;
        chk("remu rst mdErr", 8'(mdErr), 8'h0);
        chk("remu rst mdStart", 8'(mdStart), 8'h0);
        rst_n = 1'b1;
        #1;
        chk("remu reissue mdStart", 8'(mdStart), 8'h1);
        tick();
        mdVld = 1'b1;
        #1;
        chk("remu done regWrite", 8'(regWrite), 8'h1);
        chk("remu done wdSrc", 8'(wdSrc), 8'h2);
        tick();
        mdVld = 1'b0;

        // DIV_EN=0 instance: DIVU/REMU illegal, MUL still legal
        set_cmd(7'b0110011, 3'b101, 7'b0000001);
        #1;
        chk("nodiv divu illegal", 8'(nd_illegal), 8'h1);
        chk("nodiv divu mdStart", 8'(nd_mdStart), 8'h0);
        chk("nodiv divu regWrite", 8'(nd_regWrite), 8'h0);
        chk("nodiv divu pcEn", 8'(nd_pcEn), 8'h1);
        chk("div divu illegal", 8'(illegal), 8'h0);
        set_cmd(7'b0110011, 3'b111, 7'b0000001);
        #1;
        chk("nodiv remu illegal", 8'(nd_illegal), 8'h1);
        chk("nodiv remu mdStart", 8'(nd_mdStart), 8'h0);
        set_cmd(7'b0110011, 3'b000, 7'b0000001);
        #1;
        chk("nodiv mul illegal", 8'(nd_illegal), 8'h0);
        chk("nodiv mul mdStart", 8'(nd_mdStart), 8'h1);
        tick();
        mdVld = 1'b1;
        #1;
        chk("nodiv mul done regWrite", 8'(nd_regWrite), 8'h1);
        tick();
        mdVld = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
